// File: rtl/aes_ahb_block_ingress.sv
// AHB-Lite write slave that packs DATA_W-wide beats into 128-bit blocks and queues them for the AES core.
// Optional feature macro: AES_INGRESS_STATUS_EN (legal status reads returning FIFO/assembly state).
module aes_ahb_block_ingress #(
   parameter int DATA_W = 128,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 3
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              HSELx,
   input  logic [31:0]       HADDR,
   input  logic [1:0]        HTRANS,
   input  logic              HWRITE,
   input  logic [2:0]        HSIZE,
   input  logic [2:0]        HBURST,
   input  logic [DATA_W-1:0] HWDATA,
   input  logic              HREADY,
   output logic [DATA_W-1:0] HRDATA,
   output logic              HREADYOUT,
   output logic              HRESP,
   output logic [127:0]      blk_data,
   output logic              blk_valid,
   input  logic              blk_ready,
   output logic [CNT_W-1:0]  blk_cnt
);
   localparam int               BEATS     = 128 / DATA_W;
   localparam int               PTR_W     = $clog2(DEPTH);
   localparam logic [2:0]       SIZE_OK   = 3'($clog2(DATA_W / 8));
   localparam logic [1:0]       LAST_BEAT = 2'(BEATS - 1);
   localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_DATA  = 3'd1;
   localparam logic [2:0] S_STALL = 3'd2;
   localparam logic [2:0] S_ERR1  = 3'd3;
   localparam logic [2:0] S_ERR2  = 3'd4;

   logic [2:0]       state_q, state_d;
   logic [1:0]       beat_q, beat_d;
   logic             rd_q, rd_d;
   logic [127:0]     asm_q, asm_d;
   logic [127:0]     fifo_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic         addr_ph_s, legal_s, dir_ok_s, burst_ok_s;
   logic         full_s, empty_s, pop_s, push_s, wbeat_s, last_s, stall_s;
   logic [2:0]   addr_next_s;
   logic [6:0]   lane_hi_s;
   logic [127:0] blk_in_s;
   logic         unused_s;

   assign unused_s   = ^{HADDR, HTRANS[0]};
   assign addr_ph_s  = HSELx && HREADY && HTRANS[1];
   assign burst_ok_s = (HBURST == 3'b000) || (HBURST == 3'b001) ||
                       (HBURST == 3'b011) || (HBURST == 3'b101);
   assign legal_s    = dir_ok_s && (HSIZE == SIZE_OK) && burst_ok_s;

   assign full_s    = (cnt_q == CNT_FULL);
   assign empty_s   = (cnt_q == {CNT_W{1'b0}});
   assign pop_s     = blk_ready && !empty_s;
   assign wbeat_s   = ((state_q == S_DATA) && !rd_q) || (state_q == S_STALL);
   assign last_s    = (beat_q == LAST_BEAT);
   // A completing beat waits only when no slot is free and none frees this cycle.
   assign stall_s   = wbeat_s && last_s && full_s && !pop_s;
   assign push_s    = wbeat_s && last_s && !stall_s;
   assign lane_hi_s = 7'(127 - int'(beat_q) * DATA_W);

   assign HREADYOUT = (state_q != S_ERR1) && !stall_s;
   assign HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);
   assign blk_valid = !empty_s;
   assign blk_cnt   = cnt_q;
   assign blk_data  = empty_s ? 128'd0 : fifo_q[rd_ptr_q];

`ifdef AES_INGRESS_STATUS_EN
   assign dir_ok_s = 1'b1;

   // Status word is only driven during the data phase of a read.
   always_comb begin
      HRDATA = {DATA_W{1'b0}};
      if ((state_q == S_DATA) && rd_q) begin
         HRDATA = DATA_W'({cnt_q, beat_q, full_s, empty_s});
      end else begin
         HRDATA = {DATA_W{1'b0}};
      end
   end
`else
   assign dir_ok_s = HWRITE;
   assign HRDATA   = {DATA_W{1'b0}};
`endif

   // Block input: assembled lanes with the final lane taken straight from the bus.
   always_comb begin
      blk_in_s               = asm_q;
      blk_in_s[DATA_W-1:0]   = HWDATA;
   end

   // Follow-on state decided by the address phase sampled this cycle.
   always_comb begin
      addr_next_s = S_IDLE;
      if (addr_ph_s) begin
         if (legal_s) addr_next_s = S_DATA;
         else         addr_next_s = S_ERR1;
      end else begin
         addr_next_s = S_IDLE;
      end
   end

   // Bus FSM, beat counter and assembly lanes.
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      asm_d   = asm_q;
      case (state_q)
         S_IDLE:          state_d = addr_next_s;
         S_DATA, S_STALL: state_d = stall_s ? S_STALL : addr_next_s;
         S_ERR1:          state_d = S_ERR2;
         S_ERR2:          state_d = S_IDLE;
         default:         state_d = S_IDLE;
      endcase
      if (state_d == S_DATA) rd_d = !HWRITE;
      else                   rd_d = 1'b0;
      if (wbeat_s && !stall_s) begin
         asm_d[lane_hi_s -: DATA_W] = HWDATA;
         beat_d = last_s ? 2'd0 : beat_q + 2'd1;
      end else begin
         beat_d = beat_q;
      end
   end

   // Occupancy: simultaneous push and pop leave it unchanged.
   always_comb begin
      cnt_d = cnt_q;
      case ({push_s, pop_s})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Control registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q  <= S_IDLE;
         beat_q   <= 2'd0;
         rd_q     <= 1'b0;
         asm_q    <= 128'd0;
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         cnt_q    <= {CNT_W{1'b0}};
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         rd_q    <= rd_d;
         asm_q   <= asm_d;
         cnt_q   <= cnt_d;
         if (push_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_s)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
   end

   // Block storage; contents are don't-care while the slot is empty.
   always_ff @(posedge clk) begin
      if (push_s) fifo_q[wr_ptr_q] <= blk_in_s;
   end
endmodule
